// File: rtl/reg_bank_decoded.sv
// General-purpose register bank with a gated write decoder, two combinational
// read ports (optional write-back bypass) and a per-register busy scoreboard.
module reg_bank_decoded #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 3,
   parameter int NUM_REGS = 8,
   parameter int BYPASS   = 1,
   parameter int ZERO_R0  = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                Lreg,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   output logic [NUM_REGS-1:0] wr_onehot,
   input  logic [ADDR_W-1:0]   rd_addr_a,
   output logic [DATA_W-1:0]   rd_data_a,
   input  logic [ADDR_W-1:0]   rd_addr_b,
   output logic [DATA_W-1:0]   rd_data_b,
   input  logic                iss_en,
   input  logic [ADDR_W-1:0]   iss_addr,
   output logic                busy_a,
   output logic                busy_b,
   output logic                stall,
   output logic [NUM_REGS-1:0] busy_vec
);

   logic [NUM_REGS*DATA_W-1:0] reg_flat;

   // Implemented and not the hard-wired zero register.
   function automatic logic writable(input logic [ADDR_W-1:0] a);
      return (32'(a) < NUM_REGS) && !((ZERO_R0 != 0) && (a == '0));
   endfunction

   function automatic logic fwd_hit(input logic [ADDR_W-1:0] a);
      return (BYPASS != 0) && Lreg && (wr_addr == a) && writable(a);
   endfunction

   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (a == ADDR_W'(i)) v = reg_flat[i*DATA_W +: DATA_W];
      end
      if (!writable(a))
         v = '0;
      else if (fwd_hit(a))
         v = wr_data;
      return v;
   endfunction

   function automatic logic busy_of(input logic [ADDR_W-1:0] a);
      logic b;
      b = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (a == ADDR_W'(i)) b = busy_vec[i];
      end
      return b && writable(a) && !fwd_hit(a);
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         logic [DATA_W-1:0] data_reg;
         logic              busy_reg;
         logic              iss_hit;

         assign wr_onehot[gi] = Lreg && (wr_addr == ADDR_W'(gi)) && writable(ADDR_W'(gi));
         assign iss_hit       = iss_en && (iss_addr == ADDR_W'(gi)) && writable(ADDR_W'(gi));

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               data_reg <= '0;
               busy_reg <= 1'b0;
            end else begin
               if (wr_onehot[gi]) data_reg <= wr_data;
               // A new producer outranks the one retiring in the same cycle.
               if (iss_hit)
                  busy_reg <= 1'b1;
               else if (wr_onehot[gi])
                  busy_reg <= 1'b0;
            end
         end

         assign reg_flat[gi*DATA_W +: DATA_W] = data_reg;
         assign busy_vec[gi]                  = busy_reg;
      end
   endgenerate

   always_comb begin
      rd_data_a = read_port(rd_addr_a);
      rd_data_b = read_port(rd_addr_b);
      busy_a    = busy_of(rd_addr_a);
      busy_b    = busy_of(rd_addr_b);
      stall     = busy_a | busy_b;
   end

endmodule

// File: tb/tb_reg_bank_decoded.sv
// Scoreboard bench: two configurations share stimulus; a monitor compares every
// cycle's combinational outputs against expectations queued by the driver.
module tb_reg_bank_decoded;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        Lreg = 1'b0;
   logic        iss_en = 1'b0;
   logic [2:0]  wr_addr = '0, rd_addr_a = '0, rd_addr_b = '0, iss_addr = '0;
   logic [15:0] wr_data = '0;

   logic [7:0]  oh0, bv0;
   logic [15:0] ra0, rb0;
   logic        ba0, bb0, st0;
   logic [5:0]  oh1, bv1;
   logic [15:0] ra1, rb1;
   logic        ba1, bb1, st1;

   always #5 clk = ~clk;

   reg_bank_decoded #(.DATA_W(16), .ADDR_W(3), .NUM_REGS(8), .BYPASS(1), .ZERO_R0(0)) dut0 (
      .clk(clk), .rst(rst), .Lreg(Lreg), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_onehot(oh0), .rd_addr_a(rd_addr_a), .rd_data_a(ra0), .rd_addr_b(rd_addr_b),
      .rd_data_b(rb0), .iss_en(iss_en), .iss_addr(iss_addr), .busy_a(ba0), .busy_b(bb0),
      .stall(st0), .busy_vec(bv0));

   reg_bank_decoded #(.DATA_W(16), .ADDR_W(3), .NUM_REGS(6), .BYPASS(0), .ZERO_R0(1)) dut1 (
      .clk(clk), .rst(rst), .Lreg(Lreg), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_onehot(oh1), .rd_addr_a(rd_addr_a), .rd_data_a(ra1), .rd_addr_b(rd_addr_b),
      .rd_data_b(rb1), .iss_en(iss_en), .iss_addr(iss_addr), .busy_a(ba1), .busy_b(bb1),
      .stall(st1), .busy_vec(bv1));

   typedef struct packed {
      logic [7:0]  onehot;
      logic [15:0] ra;
      logic [15:0] rb;
      logic        ba;
      logic        bb;
      logic        st;
      logic [7:0]  bv;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   logic [15:0] mem [2][8];
   bit          bsy [2][8];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_txn = 0;

   // Configuration 0: 8 regs, bypass, no zero reg. Configuration 1: 6 regs, no bypass, zero R0.
   function automatic int  nregs(int c); return (c == 0) ? 8 : 6; endfunction
   function automatic bit  byp(int c);   return c == 0; endfunction
   function automatic bit  zr(int c);    return c == 1; endfunction
   function automatic bit  ok(int c, int a); return (a < nregs(c)) && !(zr(c) && a == 0); endfunction

   function automatic bit fwd(int c, int a);
      return byp(c) && Lreg && (int'(wr_addr) == a);
   endfunction

   function automatic logic [15:0] rd_model(int c, int a);
      if (!ok(c, a)) return 16'h0000;
      if (fwd(c, a)) return wr_data;
      return mem[c][a];
   endfunction

   function automatic bit busy_model(int c, int a);
      return ok(c, a) && bsy[c][a] && !fwd(c, a);
   endfunction

   function automatic exp_t expect_now(int c);
      exp_t e;
      e = '0;
      if (Lreg && ok(c, int'(wr_addr))) e.onehot = 8'(1) << wr_addr;
      e.ra = rd_model(c, int'(rd_addr_a));
      e.rb = rd_model(c, int'(rd_addr_b));
      e.ba = busy_model(c, int'(rd_addr_a));
      e.bb = busy_model(c, int'(rd_addr_b));
      e.st = e.ba | e.bb;
      for (int i = 0; i < nregs(c); i++) e.bv[i] = bsy[c][i];
      return e;
   endfunction

   task automatic cyc(input bit r, input bit l, input int wa, input logic [15:0] wd,
                      input int a, input int b, input bit ie, input int ia);
      @(posedge clk);
      #1;
      rst = r; Lreg = l; wr_addr = 3'(wa); wr_data = wd;
      rd_addr_a = 3'(a); rd_addr_b = 3'(b); iss_en = ie; iss_addr = 3'(ia);
      for (int c = 0; c < 2; c++) begin
         if (r) begin
            for (int i = 0; i < 8; i++) begin
               mem[c][i] = 16'h0000;
               bsy[c][i] = 1'b0;
            end
         end
      end
      q0.push_back(expect_now(0));
      q1.push_back(expect_now(1));
      // Model the effect of the coming rising edge.
      if (!r) begin
         for (int c = 0; c < 2; c++) begin
            if (l && ok(c, wa)) begin
               mem[c][wa] = wd;
               bsy[c][wa] = 1'b0;
            end
            if (ie && ok(c, ia)) bsy[c][ia] = 1'b1;
         end
      end
   endtask

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s dut%0d txn %0d: got %h expected %h", nm, d, n_txn, act, want);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q0.size() > 0 && q1.size() > 0) begin
         e = q0.pop_front();
         chk("wr_onehot", 0, 32'(oh0), 32'(e.onehot));
         chk("rd_data_a", 0, 32'(ra0), 32'(e.ra));
         chk("rd_data_b", 0, 32'(rb0), 32'(e.rb));
         chk("busy_a",    0, 32'(ba0), 32'(e.ba));
         chk("busy_b",    0, 32'(bb0), 32'(e.bb));
         chk("stall",     0, 32'(st0), 32'(e.st));
         chk("busy_vec",  0, 32'(bv0), 32'(e.bv));
         e = q1.pop_front();
         chk("wr_onehot", 1, 32'(oh1), 32'(e.onehot));
         chk("rd_data_a", 1, 32'(ra1), 32'(e.ra));
         chk("rd_data_b", 1, 32'(rb1), 32'(e.rb));
         chk("busy_a",    1, 32'(ba1), 32'(e.ba));
         chk("busy_b",    1, 32'(bb1), 32'(e.bb));
         chk("stall",     1, 32'(st1), 32'(e.st));
         chk("busy_vec",  1, 32'(bv1), 32'(e.bv));
         $display("txn %0d rst=%b L=%b wa=%0d wd=%h ra=%0d rb=%0d iss=%b/%0d | d0 a=%h b=%h st=%b bv=%h | d1 a=%h b=%h st=%b bv=%h",
                  n_txn, rst, Lreg, wr_addr, wr_data, rd_addr_a, rd_addr_b, iss_en, iss_addr,
                  ra0, rb0, st0, bv0, ra1, rb1, st1, bv1);
         n_txn++;
      end
   end

   initial begin
      //    rst L  wa wd        a  b  ie ia
      cyc(1, 0, 0, 16'h0000, 0, 0, 0, 0);
      cyc(0, 1, 3, 16'h1234, 3, 0, 0, 0);
      cyc(0, 0, 0, 16'h0000, 3, 3, 0, 0);
      cyc(1, 0, 0, 16'h0000, 3, 3, 0, 0);   // asynchronous reset between edges
      cyc(0, 1, 5, 16'hBEEF, 5, 0, 0, 0);
      cyc(0, 0, 5, 16'h5555, 5, 5, 0, 0);
      cyc(0, 1, 2, 16'h0001, 0, 0, 0, 0);
      cyc(0, 1, 2, 16'h00AA, 0, 2, 0, 0);   // bypass vs no bypass
      cyc(0, 0, 0, 16'h0000, 2, 2, 1, 4);
      cyc(0, 0, 0, 16'h0000, 4, 1, 0, 0);   // RAW hazard
      cyc(0, 1, 4, 16'h4444, 4, 1, 0, 0);   // write-back of the pending result
      cyc(0, 0, 0, 16'h0000, 4, 4, 0, 0);
      cyc(0, 1, 6, 16'h6666, 0, 0, 1, 6);   // set wins over clear
      cyc(0, 0, 0, 16'h0000, 6, 6, 0, 0);
      cyc(0, 1, 6, 16'h6767, 6, 0, 0, 0);
      cyc(0, 1, 0, 16'hFFFF, 0, 7, 1, 0);   // zero / unimplemented registers
      cyc(0, 1, 7, 16'hFFFF, 0, 7, 1, 7);
      cyc(0, 0, 0, 16'h0000, 0, 7, 0, 0);
      for (int k = 0; k < 400; k++) begin
         cyc($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
             16'($urandom), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 2) == 0, $urandom_range(0, 7));
      end
      @(posedge clk);
      #1;
      Lreg = 1'b0;
      iss_en = 1'b0;
      for (int w = 0; w < 20 && (q0.size() > 0 || q1.size() > 0); w++) @(negedge clk);
      n_cmp++;
      if (q0.size() > 0 || q1.size() > 0) begin
         n_bad++;
         $display("FAIL drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/reg_bank_decoded.md
Name: reg_bank_decoded

Overview:
Parametrised general-purpose register bank for the pipelined CPU. It has an internal write-address decoder gated by the load-enable, two combinational read ports with optional write-back bypass, an optional hard-wired-zero R0, and a per-register busy scoreboard. Decode reserves destinations at issue, the write-back stage writes results, and the scoreboard drives the stall output used for RAW hazard stalls.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, register address width
NUM_REGS, 8, implemented registers (1..2**ADDR_W); addresses >= NUM_REGS are unimplemented
BYPASS, 1, 1 = read ports forward the same-cycle write-back data; 0 = no forwarding
ZERO_R0, 0, 1 = register 0 reads 0, ignores writes and is never busy

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
Lreg  in  1  write-back load enable
wr_addr  in  ADDR_W  write-back destination
wr_data  in  DATA_W  write-back data
wr_onehot  out  NUM_REGS  decoded write enables (combinational)
rd_addr_a  in  ADDR_W  read port A address
rd_data_a  out  DATA_W  read port A data
rd_addr_b  in  ADDR_W  read port B address
rd_data_b  out  DATA_W  read port B data
iss_en  in  1  decode stage issues an instruction with a destination
iss_addr  in  ADDR_W  destination being reserved
busy_a  out  1  operand A pending
busy_b  out  1  operand B pending
stall  out  1  busy_a | busy_b
busy_vec  out  NUM_REGS  scoreboard state

Behaviour:
- Reset (rst=1, asynchronous): all registers = 0 and busy_vec = 0 immediately, with no clock needed. While rst is held, writes and issues are ignored. rd_data_* then reads 0, except the bypass path, which follows the normal rules.
- Decode: wr_onehot[i] = Lreg & (wr_addr==i) for i < NUM_REGS. If Lreg=0 or wr_addr >= NUM_REGS, the vector is all zero. With ZERO_R0=1, bit 0 is forced to 0.
- Write: on the rising edge of clk, the register flagged in wr_onehot takes wr_data. Latency is 1 cycle, so the value is architecturally visible from the next cycle.
- Read (per port, combinational, zero latency):
  - Unimplemented address, or address 0 with ZERO_R0=1 -> 0.
  - Otherwise, BYPASS=1 and Lreg and wr_addr==rd_addr and that address is writable -> wr_data.
  - Otherwise -> the stored value.
- Scoreboard, evaluated at each rising edge of clk:
  - Lreg with an implemented, writable wr_addr clears busy[wr_addr].
  - iss_en with an implemented, writable iss_addr sets busy[iss_addr].
  - If both target the same register in one cycle, set wins (the new producer outranks the retiring one).
  - Issues to unimplemented or zero registers are ignored.
  - Re-issuing to a register that is already busy keeps it busy. There is no counting, so only one outstanding producer per register is supported.
- Busy outputs (combinational):
  - busy_a = busy[rd_addr_a] & ~(BYPASS & Lreg & wr_addr==rd_addr_a). This means a result being written this cycle does not stall when bypass is enabled.
  - Unimplemented or zero-register addresses report not-busy.
  - busy_b is the same for port B.
- stall is purely combinational from busy_a and busy_b. The decode stage must hold iss_en low while stall=1; the block does not itself enforce this.
- Multiple drivers are not possible: there is exactly one write port. Read ports are independent, and both may address the same register.

Test Plan:
- Reset mid-write: write R3=0x1234, then assert rst asynchronously between edges -> R3 reads 0x0000 and busy_vec=0 without waiting for a clock edge.
- Decode/write: Lreg=1, wr_addr=5, wr_data=0xBEEF -> wr_onehot=8'b00100000 that cycle; from the next cycle rd_addr_a=5 reads 0xBEEF. Lreg=0 -> wr_onehot=0 and no register changes.
- Bypass: BYPASS=1, R2 holds 0x0001, same cycle Lreg=1, wr_addr=2, wr_data=0x00AA, rd_addr_b=2 -> rd_data_b=0x00AA. With BYPASS=0, the same stimulus reads 0x0001.
- Scoreboard hazard: iss_en with iss_addr=4, then next cycle rd_addr_a=4 -> busy_a=1, stall=1. In the write-back cycle with wr_addr=4 and BYPASS=1 -> stall=0 and busy[4] clears at the edge.
- Set-over-clear: in the same cycle Lreg=1, wr_addr=6 and iss_en=1, iss_addr=6 -> after the edge R6 holds the new data and busy[6]=1.
- ZERO_R0=1, NUM_REGS=6: write 0xFFFF to R0 and to R7 -> both read 0, wr_onehot=0, and iss_addr=0 and iss_addr=7 leave busy_vec unchanged.
